// File: rtl/unified_mem_arbiter.sv
// Shares one single-port 32-bit memory between instruction fetch and data load/store.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE (default: data wins).
module unified_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   d_req;
  logic   grant_i, grant_d;

  assign d_req = d_read | d_write;

  // The completing requester's req is still high in its BUSY state, so only
  // the other side can be granted there.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_d_q) grant_i = 1'b1;
          else          grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else begin
          grant_i = if_req;
          grant_d = d_req;
        end
      end
      BUSY_I:  grant_d = d_req;
      BUSY_D:  grant_i = if_req;
      default: ;
    endcase
    // Reset suppresses any grant asserted in the same cycle, including writes.
    grant_i = grant_i & rst;
    grant_d = grant_d & rst;
  end

  always_comb begin
    state_d  = grant_d ? BUSY_D : (grant_i ? BUSY_I : IDLE);
    last_d_d = grant_d ? 1'b1 : (grant_i ? 1'b0 : last_d_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign if_ready  = (state_q == BUSY_I);
  assign d_ready   = (state_q == BUSY_D);
  assign if_rdata  = if_ready ? mem_rdata : 32'h0;
  assign d_rdata   = d_ready ? mem_rdata : 32'h0;

  assign mem_en    = grant_i | grant_d;
  assign mem_we    = grant_d & d_write;
  assign mem_addr  = grant_d ? d_addr[ADDR_W+1:2] :
                     (grant_i ? if_addr[ADDR_W+1:2] : '0);
  assign mem_wdata = grant_d ? d_wdata : 32'h0;

  // Byte offset and high address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule
